csa_shared_ctrl: RTL

CSA_SHARED_CTRL -- requirements
Module: csa_shared_ctrl

---
 rtl/csa_shared_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/csa_shared_ctrl.sv
// csa_shared_ctrl: two-requester add/subtract unit built around a single
// 8-bit carry-select adder slice. It walks the operands one byte per cycle,
// least significant byte first.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid / reqN_ready     request handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b              operands, W = 8*NBYTES bits each
//   reqN_sub                    1 = A-B, 0 = A+B
//   rsp_valid / rsp_ready       response handshake
//   rsp_id                      requester that owns the result
//   rsp_sum, rsp_cout           result and final carry (1 = no borrow on subtract)

// csa: 8-bit carry-select slice. The low nibble ripples from cin0. The high
// nibble is computed twice: once with carry-in 0 and once with carry-in cin1.
// The low-nibble carry picks one of the two. With cin1 tied to 1 this is an
// ordinary 8-bit adder whose carry-in is cin0.
module csa (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin0,
  input  logic       cin1,
  output logic [7:0] s,
  output logic       cout
);
  logic [4:0] lo;
  logic [4:0] hi0;
  logic [4:0] hi1;

  assign lo   = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, cin0};
  assign hi0  = {1'b0, a[7:4]} + {1'b0, b[7:4]};
  assign hi1  = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'd0, cin1};
  assign s    = {(lo[4] ? hi1[3:0] : hi0[3:0]), lo[3:0]};
  assign cout = lo[4] ? hi1[4] : hi0[4];
endmodule

module csa_shared_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [8*NBYTES-1:0] req0_a,
  input  logic [8*NBYTES-1:0] req0_b,
  input  logic                req0_sub,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [8*NBYTES-1:0] req1_a,
  input  logic [8*NBYTES-1:0] req1_b,
  input  logic                req1_sub,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [8*NBYTES-1:0] rsp_sum,
  output logic                rsp_cout
);
  localparam int W  = 8 * NBYTES;
  localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_reg, state_next;
  logic [KW-1:0] k_reg;
  logic          carry_reg;
  logic          id_reg;
  logic          prio_reg;      // 1 = req1 wins when both are valid
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;         // already inverted for subtract
  logic [7:0]    res_reg [NBYTES];

  logic [7:0]    a_byte [NBYTES];
  logic [7:0]    b_byte [NBYTES];
  logic [7:0]    slice_s;
  logic          slice_cout;
  logic          grant0, grant1, accept, last_byte;
  logic [W-1:0]  op_b;
  logic          op_sub;

  // Byte lanes of the captured operands and of the assembled result.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    assign a_byte[gi]            = a_reg[gi*8 +: 8];
    assign b_byte[gi]            = b_reg[gi*8 +: 8];
    assign rsp_sum[gi*8 +: 8]    = res_reg[gi];
  end

  csa u_csa (
    .a    (a_byte[k_reg]),
    .b    (b_byte[k_reg]),
    .cin0 (carry_reg),
    .cin1 (1'b1),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // Round-robin: a lone requester always wins; on contention prio_reg decides.
  assign grant0    = req0_valid & (~req1_valid | ~prio_reg);
  assign grant1    = req1_valid & (~req0_valid |  prio_reg);
  assign accept    = req0_ready | req1_ready;
  assign last_byte = (k_reg == KW'(NBYTES - 1));
  assign op_b      = req1_ready ? req1_b   : req0_b;
  assign op_sub    = req1_ready ? req1_sub : req0_sub;
  assign rsp_id    = id_reg;
  assign rsp_cout  = carry_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)    state_next = BUSY;
      BUSY:    if (last_byte) state_next = DONE;
      DONE:    if (rsp_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Outputs. The readys are also gated by rst_n, so they drop as soon as
  // reset is asserted even while the valids are still high.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        req0_ready = rst_n & grant0;
        req1_ready = rst_n & grant1;
      end
      DONE:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: capture on accept, then one byte per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_reg     <= '0;
      carry_reg <= 1'b0;
      id_reg    <= 1'b0;
      prio_reg  <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      for (int i = 0; i < NBYTES; i++) res_reg[i] <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: if (accept) begin
          a_reg     <= req1_ready ? req1_a : req0_a;
          b_reg     <= op_sub ? ~op_b : op_b;
          carry_reg <= op_sub;   // +1 completes the two's complement of B
          id_reg    <= req1_ready;
          prio_reg  <= req0_ready;
          k_reg     <= '0;
        end
        BUSY: begin
          res_reg[k_reg] <= slice_s;
          carry_reg      <= slice_cout;
          k_reg          <= last_byte ? '0 : k_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
